// File: rtl/fpnew_divsqrt_mant_iter_if.sv
// Start/kill/ready/done handshake and operand/result bundle between the divsqrt
// wrapper (master) and the iterative mantissa engine (slave).
`timescale 1ns/1ps
interface fpnew_divsqrt_mant_iter_if #(
    parameter int unsigned MantWidth = 53
);
    logic                 div_start_i;
    logic                 sqrt_start_i;
    logic                 kill_i;
    logic [MantWidth-1:0] mant_a_i;
    logic [MantWidth-1:0] mant_b_i;
    logic                 exp_odd_i;
    logic                 ready_o;
    logic                 done_o;
    logic [MantWidth+1:0] result_o;
    logic                 sticky_o;
    logic                 busy_o;

    modport master (
        output div_start_i, sqrt_start_i, kill_i, mant_a_i, mant_b_i, exp_odd_i,
        input  ready_o, done_o, result_o, sticky_o, busy_o
    );

    modport slave (
        input  div_start_i, sqrt_start_i, kill_i, mant_a_i, mant_b_i, exp_odd_i,
        output ready_o, done_o, result_o, sticky_o, busy_o
    );
endinterface

// File: rtl/fpnew_divsqrt_mant_iter.sv
// Radix-2 restoring mantissa divider / square-root engine, one result bit per cycle.
// Outputs are driven from registers only; ready depends on state alone.
`timescale 1ns/1ps
module fpnew_divsqrt_mant_iter #(
    parameter int unsigned MantWidth = 53
) (
    input logic                      clk_i,
    input logic                      rst_i,
    fpnew_divsqrt_mant_iter_if.slave bus
);
    localparam int unsigned W    = MantWidth;
    localparam int unsigned CntW = $clog2(W + 3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CntW-1:0] cnt;
    logic            is_sqrt;
    logic [W-1:0]    divisor;
    logic [W+3:0]    rem, rem_nxt;
    logic [2*W+1:0]  rad;
    logic [W+1:0]    quo, quo_nxt;
    logic            sticky;
    logic            accept;
    logic [W+3:0]    rem_shift;
    logic [W+3:0]    trial;
    logic [W+3:0]    div_ext;

    assign accept = (state != BUSY) && (bus.div_start_i || bus.sqrt_start_i) && !bus.kill_i;

    always_comb begin
        state_nxt = state;
        if (bus.kill_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = BUSY;
                BUSY:    if (cnt == CntW'(1)) state_nxt = DONE;
                DONE:    state_nxt = accept ? BUSY : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Sqrt brings down two radicand bits per step and tries root*4+1;
    // division compares the shifted partial remainder against the divisor.
    always_comb begin
        rem_shift = {rem[W+1:0], rad[2*W+1 -: 2]};
        trial     = {quo, 2'b01};
        div_ext   = {4'b0000, divisor};
        rem_nxt   = rem;
        quo_nxt   = quo;
        if (is_sqrt) begin
            if (rem_shift >= trial) begin
                rem_nxt = rem_shift - trial;
                quo_nxt = {quo[W:0], 1'b1};
            end else begin
                rem_nxt = rem_shift;
                quo_nxt = {quo[W:0], 1'b0};
            end
        end else begin
            if (rem >= div_ext) begin
                rem_nxt = (rem - div_ext) << 1;
                quo_nxt = {quo[W:0], 1'b1};
            end else begin
                rem_nxt = rem << 1;
                quo_nxt = {quo[W:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            is_sqrt <= 1'b0;
            divisor <= '0;
            rem     <= '0;
            rad     <= '0;
            quo     <= '0;
            sticky  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                is_sqrt <= !bus.div_start_i;
                divisor <= bus.mant_b_i;
                quo     <= '0;
                sticky  <= 1'b0;
                if (bus.div_start_i) begin
                    cnt <= CntW'(W + 2);
                    rem <= {4'b0000, bus.mant_a_i};
                    rad <= '0;
                end else begin
                    cnt <= CntW'(W + 1);
                    rem <= '0;
                    rad <= bus.exp_odd_i ? {bus.mant_a_i, {(W + 2){1'b0}}}
                                         : {1'b0, bus.mant_a_i, {(W + 1){1'b0}}};
                end
            end else if (state == BUSY) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                rad <= rad << 2;
                cnt <= cnt - CntW'(1);
                // A zero divisor leaves the dividend in the remainder; report no sticky then.
                if (cnt == CntW'(1))
                    sticky <= (rem_nxt != '0) && (is_sqrt || (divisor != '0));
            end
        end
    end

    assign bus.ready_o  = (state != BUSY);
    assign bus.busy_o   = (state == BUSY);
    assign bus.done_o   = (state == DONE);
    assign bus.result_o = quo;
    assign bus.sticky_o = sticky;
endmodule

// File: tb/tb_fpnew_divsqrt_mant_iter.sv
// Scoreboard bench for the mantissa divsqrt engine at W=8: the driver queues
// arithmetic-model results, the negedge monitor checks every done pulse and status probe.
`timescale 1ns/1ps
module tb_fpnew_divsqrt_mant_iter;
    localparam int W = 8;

    typedef struct {
        logic [W+1:0] res;
        logic         st;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t sb[$];
    exp_t last_e;
    exp_t mon_e;

    string        pr_name;
    bit           pr_ready, pr_busy, pr_done, pr_use_res;
    logic [W+1:0] pr_res;
    logic         pr_st;
    int           pr_seq = 0;
    int           pr_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpnew_divsqrt_mant_iter_if #(.MantWidth(W)) bus();

    fpnew_divsqrt_mant_iter #(.MantWidth(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic exp_t model(input bit is_div, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input bit odd);
        exp_t        e;
        logic [63:0] x;
        logic [63:0] r;
        e.due = 0;
        if (is_div) begin
            x = 64'(a) << (W + 1);
            if (b == '0) begin
                e.res = '1;
                e.st  = 1'b0;
            end else begin
                e.res = (W+2)'(x / 64'(b));
                e.st  = (x % 64'(b)) != 0;
            end
        end else begin
            x = 64'(a) << (odd ? W + 2 : W + 1);
            r = 0;
            while ((r + 1) * (r + 1) <= x) r = r + 1;
            e.res = (W+2)'(r);
            e.st  = (r * r) != x;
        end
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (pr_seq != pr_seen) begin
            pr_seen = pr_seq;
            cmp({pr_name, ".ready"}, 32'(bus.ready_o), 32'(pr_ready));
            cmp({pr_name, ".busy"},  32'(bus.busy_o),  32'(pr_busy));
            cmp({pr_name, ".done"},  32'(bus.done_o),  32'(pr_done));
            if (pr_use_res) begin
                cmp({pr_name, ".result"}, 32'(bus.result_o), 32'(pr_res));
                cmp({pr_name, ".sticky"}, 32'(bus.sticky_o), 32'(pr_st));
            end
        end
        if (!rst) begin
            if (bus.done_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done_o=1 want 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    cmp("latency", 32'(cyc), 32'(mon_e.due));
                    cmp("result",  32'(bus.result_o), 32'(mon_e.res));
                    cmp("sticky",  32'(bus.sticky_o), 32'(mon_e.st));
                end
            end else if (sb.size() != 0 && cyc >= sb[0].due) begin
                mon_e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_done: got done_o=0 want 1 (cycle %0d)", cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string name, input bit rdy, input bit bsy, input bit dn,
                         input bit use_res, input logic [W+1:0] res, input logic st);
        pr_name    = name;
        pr_ready   = rdy;
        pr_busy    = bsy;
        pr_done    = dn;
        pr_use_res = use_res;
        pr_res     = res;
        pr_st      = st;
        pr_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic start_op(input bit is_div, input bit both, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit odd);
        exp_t e;
        bit   eff_div;
        eff_div          = is_div | both;
        bus.div_start_i  = eff_div;
        bus.sqrt_start_i = !is_div | both;
        bus.mant_a_i     = a;
        bus.mant_b_i     = b;
        bus.exp_odd_i    = odd;
        e     = model(eff_div, a, b, odd);
        e.due = cyc + 1 + (eff_div ? W + 2 : W + 1);
        sb.push_back(e);
        last_e = e;
        tick();
        bus.div_start_i  = 1'b0;
        bus.sqrt_start_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            $display("FAIL wait_idle: got %0d pending results want 0", sb.size());
            $fatal(1, "scoreboard did not drain");
        end
        tick();
    endtask

    task automatic wait_done_cycle();
        for (int i = 0; i < 40 && cyc < last_e.due; i++) tick();
    endtask

    initial begin
        logic [W-1:0] a, b;
        bit           is_div, odd;

        rst              = 1'b1;
        bus.div_start_i  = 1'b0;
        bus.sqrt_start_i = 1'b0;
        bus.kill_i       = 1'b0;
        bus.mant_a_i     = '0;
        bus.mant_b_i     = '0;
        bus.exp_odd_i    = 1'b0;
        tick();
        probe("reset", 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        start_op(1'b1, 1'b0, 8'h80, 8'hC0, 1'b0);
        wait_idle();
        repeat (2) tick();
        probe("div80_c0_hold", 1'b1, 1'b0, 1'b0, 1'b1, 10'h155, 1'b1);
        tick();

        start_op(1'b1, 1'b0, 8'hFF, 8'h80, 1'b0);
        probe("busy0", 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        probe("busy1", 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        probe("busy2", 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        wait_idle();
        probe("divff_80_hold", 1'b1, 1'b0, 1'b0, 1'b1, 10'h3FC, 1'b0);
        tick();

        start_op(1'b0, 1'b0, 8'h80, 8'h00, 1'b0);
        wait_idle();
        probe("sqrt80_even", 1'b1, 1'b0, 1'b0, 1'b1, 10'h100, 1'b0);
        tick();
        start_op(1'b0, 1'b0, 8'h80, 8'h00, 1'b1);
        wait_idle();
        probe("sqrt80_odd", 1'b1, 1'b0, 1'b0, 1'b1, 10'h16A, 1'b1);
        tick();

        // back-to-back: div start presented in the sqrt DONE cycle
        start_op(1'b0, 1'b0, 8'hC3, 8'h00, 1'b1);
        wait_done_cycle();
        start_op(1'b1, 1'b0, 8'hA5, 8'h9B, 1'b0);
        wait_idle();

        // kill at iteration 4 with a start in the same cycle
        start_op(1'b1, 1'b0, 8'hE1, 8'h85, 1'b0);
        repeat (3) tick();
        sb.delete();
        bus.kill_i       = 1'b1;
        bus.div_start_i  = 1'b1;
        bus.mant_a_i     = 8'h99;
        tick();
        bus.kill_i       = 1'b0;
        bus.div_start_i  = 1'b0;
        probe("after_kill", 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (14) tick();
        start_op(1'b1, 1'b0, 8'hD7, 8'hB1, 1'b0);
        wait_idle();

        // illegal sqrt start while the div is busy
        start_op(1'b1, 1'b0, 8'h9C, 8'hF3, 1'b0);
        repeat (3) tick();
        bus.sqrt_start_i = 1'b1;
        bus.mant_a_i     = 8'hFF;
        bus.mant_b_i     = 8'h80;
        tick();
        bus.sqrt_start_i = 1'b0;
        wait_idle();

        start_op(1'b0, 1'b1, 8'hF0, 8'h88, 1'b1);
        wait_idle();

        start_op(1'b1, 1'b0, 8'hB7, 8'h00, 1'b0);
        wait_idle();
        probe("div_by_zero", 1'b1, 1'b0, 1'b0, 1'b1, 10'h3FF, 1'b0);
        tick();

        // reset pulsed mid-sqrt
        start_op(1'b0, 1'b0, 8'hAB, 8'h00, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        sb.delete();
        probe("mid_reset", 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        tick();
        rst = 1'b0;
        repeat (14) tick();
        probe("post_reset", 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        tick();

        for (int n = 0; n < 40; n++) begin
            is_div = 1'($urandom_range(0, 1));
            odd    = 1'($urandom_range(0, 1));
            a      = 8'($urandom) | 8'h80;
            b      = 8'($urandom) | 8'h80;
            start_op(is_div, 1'b0, a, b, odd);
            if ($urandom_range(0, 1) == 1) wait_done_cycle();
            else wait_idle();
        end
        wait_idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
